// File: rtl/shift_register_ser.sv
// Parallel-in, serial-out word shifter with a one-entry holding buffer.
// Emits a one-cycle frame strobe with the first bit of every word; back-to-back words stream gaplessly.
module shift_register_ser #(
    parameter int SHIFT_NUM = 4,
    parameter bit LSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [SHIFT_NUM-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_data,
    output logic                 o_frame,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(SHIFT_NUM + 1);

    generate
        if (SHIFT_NUM < 2) begin : g_bad_shift_num
            $error("shift_register_ser: SHIFT_NUM must be 2 or more");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SHIFT_NUM-1:0] shift_q, shift_d;
    logic [SHIFT_NUM-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 ready_q, ready_d;
    logic                 data_q, data_d;
    logic                 frame_q, frame_d;
    logic                 busy_q, busy_d;
    logic                 load;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        data_d      = data_q;
        frame_d     = 1'b0;
        busy_d      = busy_q;
        load        = 1'b0;

        // ready_q mirrors !hold_full_q, so accept and load never share an edge
        if (i_valid && ready_q) begin
            hold_d      = i_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end else begin
                    data_d = IDLE_BIT;
                    busy_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q < CNT_W'(SHIFT_NUM)) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (LSB_FIRST) begin
                        shift_d = shift_q >> 1;
                        data_d  = shift_q[1];
                    end else begin
                        shift_d = shift_q << 1;
                        data_d  = shift_q[SHIFT_NUM-2];
                    end
                end else if (hold_full_q) begin
                    load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    data_d  = IDLE_BIT;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                data_d  = IDLE_BIT;
                busy_d  = 1'b0;
            end
        endcase

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            data_d      = LSB_FIRST ? hold_q[0] : hold_q[SHIFT_NUM-1];
            frame_d     = 1'b1;
            busy_d      = 1'b1;
            bit_cnt_d   = CNT_W'(1);
            state_d     = ST_SHIFT;
        end

        ready_d = ~hold_full_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            data_q      <= IDLE_BIT;
            frame_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
            frame_q     <= frame_d;
            busy_q      <= busy_d;
        end
    end

    assign o_ready = ready_q;
    assign o_data  = data_q;
    assign o_frame = frame_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_shift_register_ser.sv
// Bench for shift_register_ser: LSB-first and MSB-first instances share stimulus; a
// deserializing monitor pops the expected word from a scoreboard queue per instance.
module tb_shift_register_ser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] i_data;
    logic       i_valid;
    logic       rdy0, dat0, frm0, bsy0;
    logic       rdy1, dat1, frm1, bsy1;

    int n_vec = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int cyc = 0;
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    int frame_cyc[$];

    logic       active[2];
    int         nb[2];
    logic [3:0] word[2];

    always #5 clk = ~clk;

    shift_register_ser #(.SHIFT_NUM(4), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_lsb (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(rdy0), .o_data(dat0), .o_frame(frm0), .o_busy(bsy0)
    );

    shift_register_ser #(.SHIFT_NUM(4), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_msb (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(rdy1), .o_data(dat1), .o_frame(frm1), .o_busy(bsy1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // scoreboard push on every accepted word
    always @(posedge clk) begin
        if (rst_n && i_valid && rdy0) begin
            q0.push_back(i_data);
            q1.push_back(i_data);
            acc_cnt++;
        end
    end

    // deserializing monitor: frame starts a word, four bits rebuild it
    always @(negedge clk) begin
        logic [1:0] od, of, ob;
        logic [3:0] exp;
        cyc++;
        od = {dat1, dat0};
        of = {frm1, frm0};
        ob = {bsy1, bsy0};
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            for (int k = 0; k < 2; k++) begin
                active[k] = 1'b0;
                nb[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (of[k]) begin
                    if (active[k]) chk($sformatf("frame_early%0d", k), nb[k], 4);
                    active[k] = 1'b1;
                    nb[k] = 0;
                    word[k] = 4'h0;
                    if (k == 0) frame_cyc.push_back(cyc);
                end
                if (active[k]) begin
                    chk($sformatf("busy%0d", k), ob[k], 1);
                    if (k == 0) word[k][nb[k]] = od[k];
                    else        word[k][3-nb[k]] = od[k];
                    nb[k]++;
                    if (nb[k] == 4) begin
                        active[k] = 1'b0;
                        exp = 'x;
                        if (k == 0 && q0.size() > 0) exp = q0.pop_front();
                        if (k == 1 && q1.size() > 0) exp = q1.pop_front();
                        chk($sformatf("word%0d", k), word[k], exp);
                    end
                end else begin
                    chk($sformatf("idle_data%0d", k), od[k], 0);
                end
            end
        end
    end

    task automatic send_word(input logic [3:0] w);
        int c0;
        c0 = acc_cnt;
        i_data = w;
        i_valid = 1'b1;
        for (int i = 0; i < 20 && acc_cnt == c0; i++) @(negedge clk);
        chk("accept", acc_cnt, c0 + 1);
    endtask

    initial begin
        logic [3:0] w;
        int c0;
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_data = 4'($urandom);

        // 1: reset state, then idle
        repeat (2) @(negedge clk);
        chk("rst_ready", rdy0, 1);
        chk("rst_data", {dat1, dat0}, 0);
        chk("rst_frame", {frm1, frm0}, 0);
        chk("rst_busy", {bsy1, bsy0}, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            i_data = 4'($urandom);
            chk("idle_out", {rdy1, rdy0, bsy1, bsy0, frm1, frm0, dat1, dat0}, 8'b1100_0000);
        end

        // 2/3: single word, bit order and latency in both orders
        w = 4'b1011;
        send_word(w);
        i_valid = 1'b0;
        chk("t2_pre_frame", frm0, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("t2_lsb_bit%0d", i), dat0, w[i-1]);
            chk($sformatf("t3_msb_bit%0d", i), dat1, w[4-i]);
            chk($sformatf("t2_frame%0d", i), {frm1, frm0}, (i == 1) ? 2'b11 : 2'b00);
            chk($sformatf("t2_busy%0d", i), {bsy1, bsy0}, 2'b11);
        end
        @(negedge clk);
        chk("t2_end_data", {dat1, dat0}, 0);
        chk("t2_end_busy", {bsy1, bsy0}, 0);
        repeat (2) @(negedge clk);

        // 4: continuous stream A, B, C
        frame_cyc.delete();
        send_word(4'hA);
        chk("t4_ready_after_acc", rdy0, 0);
        send_word(4'h5);
        send_word(4'h3);
        i_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_frames", frame_cyc.size(), 3);
        if (frame_cyc.size() == 3) begin
            chk("t4_gap_ab", frame_cyc[1] - frame_cyc[0], 4);
            chk("t4_gap_bc", frame_cyc[2] - frame_cyc[1], 4);
        end
        chk("t4_q0_empty", q0.size(), 0);
        chk("t4_q1_empty", q1.size(), 0);

        // 5: backpressure while hold buffer is full
        send_word(4'h3);
        chk("t5_ready_full", rdy0, 0);
        c0 = acc_cnt;
        i_data = 4'hC;
        @(negedge clk);
        chk("t5_not_captured", acc_cnt, c0);
        chk("t5_ready_after_load", rdy0, 1);
        @(negedge clk);
        chk("t5_captured", acc_cnt, c0 + 1);
        chk("t5_ready_again_low", {rdy1, rdy0}, 2'b00);
        i_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_q0_empty", q0.size(), 0);

        // 6: asynchronous reset mid-word with a buffered word
        send_word(4'hF);
        send_word(4'h6);
        i_valid = 1'b0;
        chk("t6_mid_busy", bsy0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", {rdy1, rdy0, bsy1, bsy0, frm1, frm0, dat1, dat0}, 8'b1100_0000);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send_word(4'h9);
        i_valid = 1'b0;
        @(negedge clk);
        chk("t6_frame_first", {frm1, frm0}, 2'b11);
        chk("t6_first_bit", {dat1, dat0}, 2'b11);
        repeat (8) @(negedge clk);
        chk("t6_q0_empty", q0.size(), 0);
        chk("t6_q1_empty", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
